// File: rtl/interval_seq_pkg.sv
// interval_seq_pkg: shared sizes and types for the interval sequencer slice.
//   CNT_W  - count/data width, must match the downstream down_counter
//   DEPTH  - interval table entries (power of two, 2..8)
//   IDX_W  - table index width
package interval_seq_pkg;

    localparam int CNT_W = 5;
    localparam int DEPTH = 4;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [IDX_W:0]   len_t;

    // A programmed length of 0, or anything past the table, plays the whole table.
    function automatic len_t clamp_len(input len_t n);
        if ((n == '0) || (n > len_t'(DEPTH))) begin
            return len_t'(DEPTH);
        end
        return n;
    endfunction

endpackage

// File: rtl/down_counter.sv
// down_counter: free-running wrapping down-counter with synchronous load.
//   clk, rst - clock, synchronous active-high reset (count -> 0)
//   load     - capture data into count on this edge
//   data     - value loaded
//   count    - current count
module down_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] data,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= data;
        end else begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/interval_table.sv
// interval_table: N x W register file holding interval lengths.
//   clk, rst        - clock, synchronous active-high reset (clears all entries)
//   we, waddr, wdata - synchronous write port
//   raddr, rdata    - combinational read port; a read and a write of the same
//                     entry in one cycle returns the old contents
module interval_table #(
    parameter int W  = 5,
    parameter int N  = 4,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/interval_sequencer.sv
// interval_sequencer: plays a programmable list of intervals through an
// external down_counter, pulsing expire at each interval end and done at the
// end of a non-repeating sequence.
//   clk, rst            - clock, synchronous active-high reset
//   cfg_we/addr/data    - interval table write port (accepted in any state)
//   start, stop         - begin (IDLE only) / abort sequence; stop wins
//   repeat_en           - restart at entry 0 after the last interval
//   num_intervals       - sequence length; 0 or > DEPTH plays the full table
//   load, data          - registered drive to down_counter
//   count               - down_counter count, watched in RUN only
//   busy                - sequence active
//   expire, expire_idx  - one-cycle pulse and index of the finished interval
//   done                - one-cycle pulse at non-repeating sequence end
//
// state | meaning
// IDLE  | waiting for start; counter free-runs and is ignored
// LOAD  | load pulse is out, counter captures data at the next edge
// RUN   | waiting for count == 0
module interval_sequencer
    import interval_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    input  logic             start,
    input  logic             stop,
    input  logic             repeat_en,
    input  logic [IDX_W:0]   num_intervals,
    output logic             load,
    output logic [CNT_W-1:0] data,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             expire,
    output logic [IDX_W-1:0] expire_idx,
    output logic             done
);

    state_t state_q, state_d;
    idx_t   idx_q, idx_d;
    len_t   len_q, len_d;
    logic   load_q, load_d;
    cnt_t   data_q, data_d;
    logic   busy_q, busy_d;
    logic   expire_q, expire_d;
    idx_t   expire_idx_q, expire_idx_d;
    logic   done_q, done_d;

    len_t   idx_inc;
    logic   last;
    idx_t   rd_addr;
    cnt_t   rd_data;

    interval_table #(
        .W (CNT_W),
        .N (DEPTH)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Index compare is done one bit wider so idx+1 == DEPTH does not wrap.
    assign idx_inc = len_t'(idx_q) + len_t'(1);
    assign last    = !(idx_inc < len_q);
    // The only reads are entry 0 (start or repeat) or the next entry in RUN.
    assign rd_addr = ((state_q == RUN) && !last) ? idx_inc[IDX_W-1:0] : '0;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        load_d       = 1'b0;
        data_d       = data_q;
        busy_d       = busy_q;
        expire_d     = 1'b0;
        expire_idx_d = expire_idx_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    idx_d   = '0;
                    len_d   = clamp_len(num_intervals);
                    load_d  = 1'b1;
                    data_d  = rd_data;
                    busy_d  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (count == '0) begin
                    expire_d     = 1'b1;
                    expire_idx_d = idx_q;
                    if (!last) begin
                        idx_d   = idx_inc[IDX_W-1:0];
                        load_d  = 1'b1;
                        data_d  = rd_data;
                        state_d = LOAD;
                    end else if (repeat_en) begin
                        idx_d   = '0;
                        load_d  = 1'b1;
                        data_d  = rd_data;
                        state_d = LOAD;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            load_q       <= 1'b0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            expire_q     <= 1'b0;
            expire_idx_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            load_q       <= load_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            expire_q     <= expire_d;
            expire_idx_q <= expire_idx_d;
            done_q       <= done_d;
        end
    end

    assign load       = load_q;
    assign data       = data_q;
    assign busy       = busy_q;
    assign expire     = expire_q;
    assign expire_idx = expire_idx_q;
    assign done       = done_q;

endmodule

// File: tb/tb_interval_sequencer.sv
// tb_interval_sequencer: interval_sequencer driving a down_counter. Expected
// expire/done events (edge number, index, done flag) are queued as each
// sequence is started and compared against the events the DUT produces.
module tb_interval_sequencer;
    import interval_seq_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_addr = '0;
    logic [CNT_W-1:0] cfg_data = '0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             repeat_en = 1'b0;
    logic [IDX_W:0]   num_intervals = '0;
    logic             load;
    logic [CNT_W-1:0] data;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             expire;
    logic [IDX_W-1:0] expire_idx;
    logic             done;

    typedef struct packed {
        logic [31:0]      cyc;
        logic [IDX_W-1:0] idx;
        logic             ex;
        logic             dn;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    interval_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .start         (start),
        .stop          (stop),
        .repeat_en     (repeat_en),
        .num_intervals (num_intervals),
        .load          (load),
        .data          (data),
        .count         (count),
        .busy          (busy),
        .expire        (expire),
        .expire_idx    (expire_idx),
        .done          (done)
    );

    down_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (data),
        .count (count)
    );

    // Advance n cycles, recording every expire/done seen on the falling edge.
    task automatic run_cycles(input int n);
        ev_t o;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (expire || done) begin
                o.cyc = cyc;
                o.idx = expire_idx;
                o.ex  = expire;
                o.dn  = done;
                obs_q.push_back(o);
            end
        end
    endtask

    task automatic push_exp(input int c, input int i, input logic d);
        ev_t e;
        e.cyc = c;
        e.idx = IDX_W'(i);
        e.ex  = 1'b1;
        e.dn  = d;
        exp_q.push_back(e);
    endtask

    task automatic cfg_write(input int a, input int v);
        cfg_we   = 1'b1;
        cfg_addr = IDX_W'(a);
        cfg_data = CNT_W'(v);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run_cycles(2);
        n_checks += 6;
        if (load !== 1'b0) $display("FAIL reset_load got=%b want=0", load); else n_pass++;
        if (data !== '0) $display("FAIL reset_data got=%0d want=0", data); else n_pass++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
        if (expire !== 1'b0) $display("FAIL reset_expire got=%b want=0", expire); else n_pass++;
        if (expire_idx !== '0) $display("FAIL reset_expire_idx got=%0d want=0", expire_idx); else n_pass++;
        if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
        rst = 1'b0;
        run_cycles(1);
    endtask

    task automatic test_two_intervals();
        int e0;
        ev_t e, o;
        cfg_write(0, 3); cfg_write(1, 0); cfg_write(2, 5); cfg_write(3, 1);
        num_intervals = 2; repeat_en = 1'b0;
        start = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 5, 0, 1'b0);
        push_exp(e0 + 7, 1, 1'b1);
        run_cycles(1);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL two_busy_rise got=%b want=1", busy); else n_pass++;
        run_cycles(7);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL two_busy_fall got=%b want=0", busy); else n_pass++;
        run_cycles(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL two_missing want cyc=%0d idx=%0d done=%b", e.cyc, e.idx, e.dn);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL two_event got cyc=%0d idx=%0d ex=%b done=%b want cyc=%0d idx=%0d ex=%b done=%b",
                                      o.cyc, o.idx, o.ex, o.dn, e.cyc, e.idx, e.ex, e.dn);
                else n_pass++;
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); n_checks++;
            $display("FAIL two_extra got cyc=%0d idx=%0d done=%b want none", o.cyc, o.idx, o.dn);
        end
    endtask

    task automatic test_full_table();
        int e0;
        ev_t e, o;
        num_intervals = 0; repeat_en = 1'b0;
        start = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 5, 0, 1'b0);
        push_exp(e0 + 7, 1, 1'b0);
        push_exp(e0 + 14, 2, 1'b0);
        push_exp(e0 + 17, 3, 1'b1);
        run_cycles(1);
        start = 1'b0;
        run_cycles(21);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL full_missing want cyc=%0d idx=%0d done=%b", e.cyc, e.idx, e.dn);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL full_event got cyc=%0d idx=%0d ex=%b done=%b want cyc=%0d idx=%0d ex=%b done=%b",
                                      o.cyc, o.idx, o.ex, o.dn, e.cyc, e.idx, e.ex, e.dn);
                else n_pass++;
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); n_checks++;
            $display("FAIL full_extra got cyc=%0d idx=%0d done=%b want none", o.cyc, o.idx, o.dn);
        end
    endtask

    task automatic test_repeat();
        int e0;
        ev_t e, o;
        for (int i = 0; i < DEPTH; i++) cfg_write(i, 2);
        num_intervals = 2; repeat_en = 1'b1;
        start = 1'b1;
        e0 = cyc + 1;
        for (int k = 1; k <= 6; k++) push_exp(e0 + 4 * k, (k - 1) % 2, k == 6);
        run_cycles(1);
        start = 1'b0;
        run_cycles(17);
        repeat_en = 1'b0;
        run_cycles(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL repeat_missing want cyc=%0d idx=%0d done=%b", e.cyc, e.idx, e.dn);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL repeat_event got cyc=%0d idx=%0d ex=%b done=%b want cyc=%0d idx=%0d ex=%b done=%b",
                                      o.cyc, o.idx, o.ex, o.dn, e.cyc, e.idx, e.ex, e.dn);
                else n_pass++;
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); n_checks++;
            $display("FAIL repeat_extra got cyc=%0d idx=%0d done=%b want none", o.cyc, o.idx, o.dn);
        end
    endtask

    task automatic test_cfg_collision();
        int e0;
        ev_t e, o;
        for (int i = 0; i < DEPTH; i++) cfg_write(i, 2);
        num_intervals = 2; repeat_en = 1'b1;
        start = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 4, 0, 1'b0);
        push_exp(e0 + 8, 1, 1'b0);
        push_exp(e0 + 12, 0, 1'b0);
        push_exp(e0 + 21, 1, 1'b0);
        push_exp(e0 + 25, 0, 1'b0);
        push_exp(e0 + 34, 1, 1'b1);
        run_cycles(1);
        start = 1'b0;
        run_cycles(3);
        cfg_we = 1'b1; cfg_addr = IDX_W'(1); cfg_data = CNT_W'(7);
        run_cycles(1);
        cfg_we = 1'b0;
        n_checks += 2;
        if (load !== 1'b1) $display("FAIL cfg_old_load got=%b want=1", load); else n_pass++;
        if (data !== CNT_W'(2)) $display("FAIL cfg_old_data got=%0d want=2", data); else n_pass++;
        run_cycles(8);
        n_checks += 2;
        if (load !== 1'b1) $display("FAIL cfg_new_load got=%b want=1", load); else n_pass++;
        if (data !== CNT_W'(7)) $display("FAIL cfg_new_data got=%0d want=7", data); else n_pass++;
        run_cycles(11);
        repeat_en = 1'b0;
        run_cycles(13);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL cfg_missing want cyc=%0d idx=%0d done=%b", e.cyc, e.idx, e.dn);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL cfg_event got cyc=%0d idx=%0d ex=%b done=%b want cyc=%0d idx=%0d ex=%b done=%b",
                                      o.cyc, o.idx, o.ex, o.dn, e.cyc, e.idx, e.ex, e.dn);
                else n_pass++;
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); n_checks++;
            $display("FAIL cfg_extra got cyc=%0d idx=%0d done=%b want none", o.cyc, o.idx, o.dn);
        end
    endtask

    task automatic test_stop();
        int e0;
        ev_t e, o;
        cfg_write(0, 3); cfg_write(1, 0);
        num_intervals = 2; repeat_en = 1'b0;
        start = 1'b1;
        run_cycles(1);
        start = 1'b0;
        run_cycles(4);
        stop = 1'b1;          // lands on the same edge that samples count == 0
        run_cycles(1);
        stop = 1'b0;
        n_checks += 2;
        if (busy !== 1'b0) $display("FAIL stop_busy got=%b want=0", busy); else n_pass++;
        if (load !== 1'b0) $display("FAIL stop_load got=%b want=0", load); else n_pass++;
        run_cycles(3);
        start = 1'b1; stop = 1'b1;
        run_cycles(2);
        start = 1'b0; stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL stop_over_start got=%b want=0", busy); else n_pass++;
        start = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 5, 0, 1'b0);
        push_exp(e0 + 7, 1, 1'b1);
        run_cycles(1);
        start = 1'b0;
        n_checks += 2;
        if (load !== 1'b1) $display("FAIL restart_load got=%b want=1", load); else n_pass++;
        if (data !== CNT_W'(3)) $display("FAIL restart_data got=%0d want=3", data); else n_pass++;
        run_cycles(9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL stop_missing want cyc=%0d idx=%0d done=%b", e.cyc, e.idx, e.dn);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL stop_event got cyc=%0d idx=%0d ex=%b done=%b want cyc=%0d idx=%0d ex=%b done=%b",
                                      o.cyc, o.idx, o.ex, o.dn, e.cyc, e.idx, e.ex, e.dn);
                else n_pass++;
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); n_checks++;
            $display("FAIL stop_extra got cyc=%0d idx=%0d done=%b want none", o.cyc, o.idx, o.dn);
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        ev_t e, o;
        cfg_write(0, 3); cfg_write(1, 0); cfg_write(2, 5); cfg_write(3, 1);
        num_intervals = 0; repeat_en = 1'b0;
        start = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 5, 0, 1'b0);
        push_exp(e0 + 7, 1, 1'b0);
        run_cycles(1);
        start = 1'b0;
        run_cycles(9);
        rst = 1'b1;
        run_cycles(1);
        rst = 1'b0;
        n_checks += 5;
        if (load !== 1'b0) $display("FAIL rmid_load got=%b want=0", load); else n_pass++;
        if (data !== '0) $display("FAIL rmid_data got=%0d want=0", data); else n_pass++;
        if (busy !== 1'b0) $display("FAIL rmid_busy got=%b want=0", busy); else n_pass++;
        if (expire !== 1'b0) $display("FAIL rmid_expire got=%b want=0", expire); else n_pass++;
        if (done !== 1'b0) $display("FAIL rmid_done got=%b want=0", done); else n_pass++;
        num_intervals = 1;
        start = 1'b1;
        e0 = cyc + 1;
        push_exp(e0 + 2, 0, 1'b1);
        run_cycles(1);
        start = 1'b0;
        n_checks += 2;
        if (load !== 1'b1) $display("FAIL rmid_start_load got=%b want=1", load); else n_pass++;
        if (data !== '0) $display("FAIL rmid_table_cleared got=%0d want=0", data); else n_pass++;
        run_cycles(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("FAIL rmid_missing want cyc=%0d idx=%0d done=%b", e.cyc, e.idx, e.dn);
            else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL rmid_event got cyc=%0d idx=%0d ex=%b done=%b want cyc=%0d idx=%0d ex=%b done=%b",
                                      o.cyc, o.idx, o.ex, o.dn, e.cyc, e.idx, e.ex, e.dn);
                else n_pass++;
            end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); n_checks++;
            $display("FAIL rmid_extra got cyc=%0d idx=%0d done=%b want none", o.cyc, o.idx, o.dn);
        end
    endtask

    initial begin
        test_reset();
        test_two_intervals();
        test_full_table();
        test_repeat();
        test_cfg_collision();
        test_stop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interval_sequencer.md
Name: interval_sequencer

Overview:
Control stage directly upstream of down_counter. It drives the counter's load/data inputs and watches its count output. It holds a small programmable table of interval lengths and plays a sequence of them: load an interval, wait for the count to reach zero, pulse an expiry event, load the next interval. Optional repeat mode restarts the sequence; a done pulse marks sequence end.

Parameters:
CNT_W, 5, count/data width; must equal down_counter width
DEPTH, 4, interval table entries; power of two, 2..8
IDX_W, $clog2(DEPTH), localparam, table index width

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_we  in  1  table write strobe
cfg_addr  in  IDX_W  table write index
cfg_data  in  CNT_W  interval value written
start  in  1  begin sequence (level, sampled in IDLE only)
stop  in  1  abort sequence
repeat_en  in  1  restart from entry 0 after last interval
num_intervals  in  IDX_W+1  sequence length; 0 or >DEPTH means DEPTH
load  out  1  to down_counter.load, registered
data  out  CNT_W  to down_counter.data, registered
count  in  CNT_W  from down_counter.count
busy  out  1  sequence active
expire  out  1  one-cycle pulse per interval end
expire_idx  out  IDX_W  table index of expiring interval, valid with expire
done  out  1  one-cycle pulse at non-repeating sequence end

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset: state IDLE; table cleared to 0; load, data, busy, expire, expire_idx, done all 0; index and length registers 0.
- Reset mid-sequence: IDLE at the next edge. No expire or done pulse.
- All outputs are registered. expire and done default to 0 every cycle.
- States: IDLE, LOAD, RUN.
- IDLE, start=1, stop=0 at edge E0:
  - idx<=0; len<=clamped num_intervals (held for the whole sequence)
  - load<=1, data<=table[0], busy<=1, go to LOAD.
- LOAD: at the next edge the counter captures data. load<=0, go to RUN. count is ignored in LOAD; it may be wrapped, e.g. 31.
- RUN, count==0 sampled at an edge:
  - expire<=1, expire_idx<=idx.
  - If idx+1<len: idx<=idx+1, load<=1, data<=table[idx+1], go to LOAD.
  - Else if repeat_en: idx<=0, load<=1, data<=table[0], go to LOAD.
  - Else: done<=1, busy<=0, go to IDLE.
- Timing: first expire is high in the cycle after edge E0+v0+2. Each subsequent expire follows the previous one by v+2 cycles, where v is the new interval. Interval value 0 is legal and gives a spacing of 2.
- stop=1 in LOAD or RUN: IDLE at the next edge. load<=0, busy<=0, no expire, no done. stop has priority over a same-edge count==0.
- In IDLE, stop=1 overrides start. start while busy is ignored.
- Table read happens at load time:
  - A write to an entry mid-sequence affects that entry's next load.
  - A write and a load of the same entry at the same edge: the old value is loaded (read-before-write).
- cfg writes are accepted in every state.
- Counter free-runs while IDLE; count is ignored there.
- repeat_en is sampled live at the end of the last interval.

Decomposition:
- Package interval_seq_pkg holds:
  - CNT_W, DEPTH
  - state_t enum {IDLE, LOAD, RUN}
  - idx_t and cnt_t typedefs
- One sub-module is natural: interval_table, a DEPTH x CNT_W register file with synchronous write, combinational read and synchronous reset to 0.
- The FSM lives in interval_sequencer.
- Bench and top-level instantiate interval_sequencer with down_counter.

Test Plan:
- Table {3,0,5,1}, num_intervals=2, repeat_en=0, start at E0 -> expire idx0 after E5; expire idx1 and done after E7; busy falls at E7.
- Same table, num_intervals=0 (means 4) -> expires after E5, E7, E14, E17 for idx 0,1,2,3; done with the last.
- Table {2,2,...}, num_intervals=2, repeat_en=1 -> expire every 4 cycles, idx 0,1,0,1...; no done. Drop repeat_en -> done with next idx1 expire.
- stop asserted in the same cycle that count==0 during RUN -> no expire; IDLE and busy=0 next cycle; a later start restarts at idx0.
- cfg write table[1]=7 at the same edge table[1] is loaded (old value 2) -> data=2 now; next pass loads 7, spacing 9.
- rst pulsed mid-RUN -> all outputs 0, table 0. start -> data=0 load, expire 2 cycles later.
